// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - non-pipelined mini-CPU sequencer owning the register file and driving the ALU
module cpu_controller #(
  parameter int DATA_W  = 16,
  parameter int INSTR_W = 18,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [2:0]         alu_opcode,
  output logic [DATA_W-1:0]  alu_r2,
  output logic [DATA_W-1:0]  alu_r3,
  output logic [3:0]         alu_d1,
  output logic [6:0]         alu_imm,
  input  logic [DATA_W-1:0]  alu_result,
  output logic               wb_valid,
  output logic [3:0]         wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic               err,
  output logic               busy,
  output logic [CNT_W-1:0]   instr_count,
  input  logic [3:0]         dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  // Highest legal opcode; 110 and 111 retire as errors.
  localparam logic [2:0] OP_LAST_LEGAL = 3'b101;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              state;
  logic [INSTR_W-1:0]  instr_q;
  logic [DATA_W-1:0]   rf [16];

  logic [2:0]          op_q;
  logic [3:0]          dest_q;
  logic [3:0]          src1_q;
  logic [3:0]          src2_q;
  logic [6:0]          imm_q;
  logic                legal_q;
  logic                do_write;

  // Field decode of the latched instruction; src2 and imm overlap by format.
  assign op_q    = instr_q[17:15];
  assign dest_q  = instr_q[14:11];
  assign src1_q  = instr_q[10:7];
  assign src2_q  = instr_q[6:3];
  assign imm_q   = instr_q[6:0];
  assign legal_q = (op_q <= OP_LAST_LEGAL);

  // Write-back happens on the edge that leaves WB, only for legal opcodes.
  assign do_write = (state == S_WB) && legal_q;

  // ALU operands always follow the latch; the RF read is combinational so
  // a dest==src instruction sees the old value during EXEC.
  assign alu_opcode = op_q;
  assign alu_d1     = dest_q;
  assign alu_imm    = imm_q;
  assign alu_r2     = rf[src1_q];
  assign alu_r3     = rf[src2_q];

  // Debug port reads zero while reset is asserted.
  assign dbg_data = rst ? '0 : rf[dbg_addr];

  // Register file: cleared by reset, written once per legal retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        rf[i] <= '0;
      end
    end else if (do_write) begin
      rf[dest_q] <= alu_result;
    end
  end

  // Sequencer FSM with registered handshake, status and write-back outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      instr_q     <= '0;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      wb_valid    <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      err         <= 1'b0;
      instr_count <= '0;
    end else begin
      wb_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            instr_q     <= instr;
            state       <= S_EXEC;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        S_EXEC: begin
          // ALU captures its operands at the end of this cycle.
          state <= S_WB;
        end
        S_WB: begin
          if (legal_q) begin
            wb_valid <= 1'b1;
            wb_addr  <= dest_q;
            wb_data  <= alu_result;
          end else begin
            err <= 1'b1;
          end
          instr_count <= instr_count + CNT_ONE;
          state       <= S_IDLE;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
        end
        default: begin
          state       <= S_IDLE;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - randomized self-checking bench for cpu_controller with a behavioural ALU and RF model
module tb_cpu_controller;

  // Narrow counter so the wrap-around can be reached in a short run.
  localparam int CNT_W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_r2;
  logic [15:0] alu_r3;
  logic [3:0]  alu_d1;
  logic [6:0]  alu_imm;
  logic [15:0] alu_result;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        err;
  logic        busy;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_rf [16];
  int          m_count;

  cpu_controller #(.DATA_W(16), .INSTR_W(18), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_opcode  (alu_opcode),
    .alu_r2      (alu_r2),
    .alu_r3      (alu_r3),
    .alu_d1      (alu_d1),
    .alu_imm     (alu_imm),
    .alu_result  (alu_result),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .err         (err),
    .busy        (busy),
    .instr_count (instr_count),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial forever #5 clk = ~clk;

  // Arithmetic of the operacoes ALU: 16-bit wrap, mul truncated, imm sign-extended.
  function automatic logic [15:0] alu_op(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [6:0] imm);
    logic [15:0] se;
    se = {{9{imm[6]}}, imm};
    case (op)
      3'd0:    return se;
      3'd1:    return a + b;
      3'd2:    return a + se;
      3'd3:    return a - b;
      3'd4:    return a - se;
      3'd5:    return a * b;
      default: return 16'h0000;
    endcase
  endfunction

  // Registered ALU: one-cycle latency from operands to result.
  always @(posedge clk) alu_result <= alu_op(alu_opcode, alu_r2, alu_r3, alu_imm);

  function automatic logic [17:0] r_type(input logic [2:0] op, input logic [3:0] d,
                                         input logic [3:0] s1, input logic [3:0] s2);
    return {op, d, s1, s2, 3'b000};
  endfunction

  function automatic logic [17:0] i_type(input logic [2:0] op, input logic [3:0] d,
                                         input logic [3:0] s1, input logic [6:0] imm);
    return {op, d, s1, imm};
  endfunction

  function automatic logic [17:0] rand_instr(input bit legal_only);
    logic [2:0]  op;
    logic [14:0] rest;
    op   = legal_only ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 7));
    rest = 15'($urandom);
    return {op, rest};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input logic [3:0] idx, input logic [15:0] val);
    dbg_addr = idx;
    #1;
    check($sformatf("reg_R%0d", idx), dbg_data, val);
  endtask

  // Issues one instruction starting at a negedge in IDLE; returns at the
  // negedge where the retire is visible (which is IDLE again).
  task automatic run_instr(input logic [17:0] ins, input bit keep_valid);
    logic [2:0]  op;
    logic [3:0]  d, s1, s2;
    logic [6:0]  imm;
    logic [15:0] exp;
    bit          legal;
    op = ins[17:15]; d = ins[14:11]; s1 = ins[10:7]; s2 = ins[6:3]; imm = ins[6:0];
    legal = (op <= 3'd5);
    instr = ins;
    instr_valid = 1'b1;
    check("ready_idle", instr_ready, 1);
    check("busy_idle", busy, 0);
    @(posedge clk);
    #1;
    if (!keep_valid) instr_valid = 1'b0;
    @(negedge clk);
    check("ready_exec", instr_ready, 0);
    check("busy_exec", busy, 1);
    check("alu_opcode", alu_opcode, op);
    check("alu_d1", alu_d1, d);
    check("alu_imm", alu_imm, imm);
    check("alu_r2", alu_r2, m_rf[s1]);
    check("alu_r3", alu_r3, m_rf[s2]);
    check("wb_valid_exec", wb_valid, 0);
    check("err_exec", err, 0);
    exp = alu_op(op, m_rf[s1], m_rf[s2], imm);
    dbg_addr = d;
    @(negedge clk);
    check("ready_wb", instr_ready, 0);
    check("busy_wb", busy, 1);
    check("wb_valid_wb", wb_valid, 0);
    @(negedge clk);
    if (legal) m_rf[d] = exp;
    m_count = (m_count + 1) % (1 << CNT_W);
    check("wb_valid", wb_valid, legal);
    check("err", err, !legal);
    if (legal) begin
      check("wb_addr", wb_addr, d);
      check("wb_data", wb_data, exp);
    end
    check("instr_count", instr_count, m_count);
    check("dbg_after_wb", dbg_data, m_rf[d]);
  endtask

  initial begin
    int c0;
    int n;
    rst = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    dbg_addr = '0;
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    m_count = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dbg", dbg_data, 0);
    check("rst_alu_opcode", alu_opcode, 0);
    check("rst_alu_r2", alu_r2, 0);
    check("rst_alu_imm", alu_imm, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", instr_ready, 1);
    check("rst_count", instr_count, 0);
    check("rst_wb_valid", wb_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    // Async reset in the EXEC cycle of "load R1,5" after R15 holds data.
    run_instr(i_type(3'd0, 4'd15, 4'd0, 7'h12), 1'b0);
    check_reg(4'd15, 16'h0012);
    @(negedge clk);
    instr = i_type(3'd0, 4'd1, 4'd0, 7'h05);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", instr_ready, 1);
    #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    m_count = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_wb_valid", wb_valid, 0);
      check("post_rst_count", instr_count, 0);
      check("post_rst_busy", busy, 0);
    end
    for (int i = 0; i < 16; i++) check_reg(4'(i), 16'h0000);
    @(negedge clk);

    // Loads, add/sub/addi, mul with truncation.
    run_instr(i_type(3'd0, 4'd1, 4'd0, 7'h05), 1'b0);
    run_instr(i_type(3'd0, 4'd2, 4'd0, 7'h7F), 1'b0);
    check_reg(4'd1, 16'h0005);
    check_reg(4'd2, 16'hFFFF);
    run_instr(r_type(3'd1, 4'd3, 4'd1, 4'd2), 1'b0);
    run_instr(r_type(3'd3, 4'd4, 4'd1, 4'd2), 1'b0);
    run_instr(i_type(3'd2, 4'd5, 4'd1, 7'h40), 1'b0);
    check_reg(4'd3, 16'h0004);
    check_reg(4'd4, 16'h0006);
    check_reg(4'd5, 16'hFFC5);
    run_instr(i_type(3'd0, 4'd6, 4'd0, 7'h3F), 1'b0);
    run_instr(r_type(3'd5, 4'd7, 4'd6, 4'd6), 1'b0);
    run_instr(i_type(3'd0, 4'd8, 4'd0, 7'h7F), 1'b0);
    run_instr(r_type(3'd5, 4'd9, 4'd8, 4'd8), 1'b0);
    check_reg(4'd7, 16'h0F81);
    check_reg(4'd9, 16'h0001);
    run_instr(i_type(3'd2, 4'd6, 4'd6, 7'h3F), 1'b0);
    run_instr(i_type(3'd2, 4'd6, 4'd6, 7'h3F), 1'b0);
    run_instr(i_type(3'd2, 4'd6, 4'd6, 7'h3F), 1'b0);
    run_instr(i_type(3'd2, 4'd6, 4'd6, 7'h03), 1'b0);
    check_reg(4'd6, 16'h00FF);
    run_instr(r_type(3'd5, 4'd10, 4'd6, 4'd2), 1'b0);
    check_reg(4'd10, 16'hFF01);

    // Illegal opcode targeting R3.
    run_instr(r_type(3'b110, 4'd3, 4'd1, 4'd2), 1'b0);
    check_reg(4'd3, 16'h0004);
    @(negedge clk);
    check("err_one_cycle", err, 0);

    // Back-to-back with instr_valid held high.
    c0 = m_count;
    for (int i = 0; i < 10; i++) run_instr(rand_instr(1'b1), 1'b1);
    instr_valid = 1'b0;
    check("b2b_count", instr_count, (c0 + 10) % (1 << CNT_W));
    @(negedge clk);

    // Random mix including illegal opcodes.
    for (int i = 0; i < 40; i++) run_instr(rand_instr(1'b0), 1'($urandom_range(0, 1)));
    instr_valid = 1'b0;
    for (int i = 0; i < 16; i++) check_reg(4'(i), m_rf[i]);
    @(negedge clk);

    // Retire up to the counter wrap.
    n = (1 << CNT_W) - m_count;
    for (int i = 0; i < n; i++) run_instr(i_type(3'd0, 4'd0, 4'd0, 7'(i)), 1'b0);
    check("count_wrap", instr_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
